// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/ack arbiter in front of the single-port 32x16
// data_memory. Port 0 is instruction fetch, port 1 is load/store.
// A grant latches the winner's request, the next cycle drives the memory,
// and the cycle after that pulses ack for the winner.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
// (port 0 wins the first tie); undefined gives fixed priority to port 0.
module mem_arbiter (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        req0,
   input  logic        we0,
   input  logic [4:0]  addr0,
   input  logic [15:0] wdata0,
   output logic        ack0,
   output logic [15:0] rdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [4:0]  addr1,
   input  logic [15:0] wdata1,
   output logic        ack1,
   output logic [15:0] rdata1,
   output logic [4:0]  mem_addr,
   output logic [15:0] mem_data,
   output logic        mem_wr_en,
   input  logic [15:0] mem_q
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [15:0] wdata;
   } mem_req_t;

   state_t         state, state_nxt;
   mem_req_t [1:0] req_in;
   mem_req_t       lat_q;
   logic           sel_q;
   logic           grant_sel;
   logic           any_req;

   assign req_in[0] = {we0, addr0, wdata0};
   assign req_in[1] = {we1, addr1, wdata1};
   assign any_req   = req0 | req1;

   // Memory sees the latched request; address/data hold between accesses.
   assign mem_addr  = lat_q.addr;
   assign mem_data  = lat_q.wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Tie goes to the port that did not win last time; a lone request wins.
   assign grant_sel = (req0 && req1) ? ~last_grant : (req1 & ~req0);

   // Remember the most recent winner; reset to 1 so port 0 takes the first tie.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         last_grant <= 1'b1;
      else if (state == IDLE && any_req)
         last_grant <= grant_sel;
   end
`else
   // Fixed priority: port 0 whenever it is requesting.
   assign grant_sel = ~req0;
`endif

   // State register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and memory write strobe.
   always_comb begin
      state_nxt = state;
      mem_wr_en = 1'b0;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  begin
                     mem_wr_en = lat_q.we;
                     state_nxt = RESP;
                  end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant latch, read-data capture and the registered ack pulse.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         lat_q  <= '0;
         sel_q  <= 1'b0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: if (any_req) begin
               sel_q <= grant_sel;
               lat_q <= req_in[grant_sel];
            end
            ACCESS: begin
               if (sel_q) ack1 <= 1'b1;
               else       ack0 <= 1'b1;
               if (!lat_q.we) begin
                  if (sel_q) rdata1 <= mem_q;
                  else       rdata0 <= mem_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against a transaction-level
// model of the arbiter plus a behavioural data_memory stub.
module tb_mem_arbiter;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [4:0]  addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, mem_wr_en;
   logic [15:0] rdata0, rdata1, mem_data, mem_q;
   logic [4:0]  mem_addr;

   int checks = 0;
   int failures = 0;

   mem_arbiter dut (
      .Clock(Clock), .Resetn(Resetn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en), .mem_q(mem_q)
   );

   always #5 Clock = ~Clock;

   // data_memory stand-in: combinational read, write on the rising edge.
   logic [15:0] stub_mem [32];
   assign mem_q = stub_mem[mem_addr];
   initial for (int i = 0; i < 32; i++) stub_mem[i] <= 16'(i * 16'h0101) ^ 16'h5A5A;
   always @(posedge Clock) if (mem_wr_en) stub_mem[mem_addr] <= mem_data;

   // Reference model: one transaction record, timed by the edge count of its grant.
   logic [15:0] ref_mem [32];
   initial for (int i = 0; i < 32; i++) ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
   int unsigned cyc = 0, m_g = 0;
   bit          m_act = 0, m_last = 1;
   int          m_p = 0;
   logic        m_we = 0;
   logic [4:0]  m_addr = '0;
   logic [15:0] m_data = '0, m_rd0 = '0, m_rd1 = '0;

   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         m_act = 0; m_last = 1; m_addr = '0; m_data = '0; m_rd0 = '0; m_rd1 = '0;
      end else begin
         cyc++;
         if (m_act && cyc == m_g + 1) begin
            if (m_we) ref_mem[m_addr] = m_data;
            else if (m_p == 0) m_rd0 = ref_mem[m_addr];
            else m_rd1 = ref_mem[m_addr];
         end else if (m_act && cyc == m_g + 2) begin
            m_act = 0;
         end else if (!m_act && (req0 || req1)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (req0 && req1) m_p = m_last ? 0 : 1;
            else m_p = req0 ? 0 : 1;
`else
            m_p = req0 ? 0 : 1;
`endif
            m_last = (m_p == 1);
            m_act  = 1;
            m_g    = cyc;
            m_we   = (m_p == 0) ? we0 : we1;
            m_addr = (m_p == 0) ? addr0 : addr1;
            m_data = (m_p == 0) ? wdata0 : wdata1;
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   int wr_cnt = 0;

   // One cycle: compare every output against the model at the falling edge,
   // then return just after the next rising edge for input updates.
   task automatic tick();
      logic in_acc, in_resp;
      @(negedge Clock);
      in_acc  = m_act && (cyc == m_g);
      in_resp = m_act && (cyc == m_g + 1);
      if (mem_wr_en) wr_cnt++;
      chk("ack0", 16'(ack0), 16'(in_resp && m_p == 0));
      chk("ack1", 16'(ack1), 16'(in_resp && m_p == 1));
      chk("mem_wr_en", 16'(mem_wr_en), 16'(in_acc && m_we));
      chk("mem_addr", 16'(mem_addr), 16'(m_addr));
      chk("mem_data", mem_data, m_data);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
      @(posedge Clock);
      #1;
   endtask

   // Full request/ack handshake from an idle arbiter; ack must arrive 2 edges after grant.
   task automatic txn(input int p, input logic we, input logic [4:0] a, input logic [15:0] d);
      int lat = -1;
      if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1; end
      else        begin we1 = we; addr1 = a; wdata1 = d; req1 = 1; end
      for (int i = 1; i <= 8; i++) begin
         tick();
         if ((p == 0 && ack0) || (p == 1 && ack1)) begin lat = i; break; end
      end
      if (p == 0) req0 = 0; else req1 = 0;
      chk("txn_latency", 16'(lat), 16'd2);
      tick();
   endtask

   initial begin
      int n, k;
      int order[$];
      int times[$];
      int exp_order[4];

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
         addr0 = 5'($urandom); addr1 = 5'($urandom); wdata0 = 16'($urandom); wdata1 = 16'($urandom);
         tick();
      end
      chk("rst_ack0", 16'(ack0), 16'd0);
      chk("rst_ack1", 16'(ack1), 16'd0);
      chk("rst_wr_en", 16'(mem_wr_en), 16'd0);
      chk("rst_rdata0", rdata0, 16'd0);
      chk("rst_mem_addr", 16'(mem_addr), 16'd0);
      req0 = 0; req1 = 0;
      Resetn = 1;
      tick(); tick();
      chk("idle_ack0", 16'(ack0), 16'd0);
      chk("idle_wr_en", 16'(mem_wr_en), 16'd0);

      // Port 1 writes BEEF to 7, port 0 reads it back.
      wr_cnt = 0;
      txn(1, 1'b1, 5'd7, 16'hBEEF);
      chk("beef_wr_cycles", 16'(wr_cnt), 16'd1);
      txn(0, 1'b0, 5'd7, 16'h0000);
      chk("beef_rdata0", rdata0, 16'hBEEF);
      chk("beef_rdata1_kept", rdata1, 16'h0000);

      // Tie with both ports holding read requests.
      we0 = 0; addr0 = 5'd1; we1 = 0; addr1 = 5'd2;
      req0 = 1; req1 = 1;
      for (int i = 0; i < 40 && order.size() < 4; i++) begin
         tick();
         if (ack0) begin order.push_back(0); times.push_back(i); req0 = 0; end
         else if (!req0) req0 = 1;
         if (ack1) begin order.push_back(1); times.push_back(i); req1 = 0; end
         else if (!req1) req1 = 1;
      end
      req0 = 0; req1 = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      chk("tie_count", 16'(order.size()), 16'd4);
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         chk("tie_order", 16'(order[i]), 16'(exp_order[i]));
         if (i > 0) chk("tie_spacing", 16'(times[i] - times[i-1]), 16'd3);
      end
      for (int i = 0; i < 4; i++) tick();

      // Reset pulsed during a port 0 write of 1234 to addr 3.
      txn(1, 1'b1, 5'd3, 16'hAAAA);
      we0 = 1; addr0 = 5'd3; wdata0 = 16'h1234; req0 = 1;
      tick();
      #1 Resetn = 0; req0 = 0;
      #2 Resetn = 1;
      n = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (ack0) n++; end
      chk("rst_access_no_ack", 16'(n), 16'd0);
      txn(0, 1'b0, 5'd3, 16'h0000);
      chk("rst_access_no_commit", rdata0, 16'hAAAA);

      // req0 held one IDLE cycle past its ack starts a second transaction.
      we0 = 0; addr0 = 5'd10; req0 = 1;
      n = 0; k = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack0) begin n++; if (k < 0) k = i; end
         if (k >= 0 && i == k + 2) req0 = 0;
      end
      req0 = 0;
      chk("held_req_acks", 16'(n), 16'd2);

      // Address changed after the grant must not affect the access.
      txn(0, 1'b1, 5'd12, 16'h1111);
      txn(0, 1'b1, 5'd13, 16'h2222);
      we0 = 0; addr0 = 5'd12; req0 = 1;
      tick();
      addr0 = 5'd13;
      chk("latched_mem_addr", 16'(mem_addr), 16'd12);
      n = 0;
      for (int i = 0; i < 6 && !ack0; i++) begin tick(); n++; end
      req0 = 0;
      chk("latched_ack_seen", 16'(ack0), 16'd1);
      chk("latched_rdata0", rdata0, 16'h1111);
      tick();

      // Random traffic with occasional asynchronous reset pulses.
      for (int t = 0; t < 1500; t++) begin
         tick();
         if (req0 && ack0) req0 = 0;
         else if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1; we0 = 1'($urandom); addr0 = 5'($urandom); wdata0 = 16'($urandom);
         end
         if (req1 && ack1) req1 = 0;
         else if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1; we1 = 1'($urandom); addr1 = 5'($urandom); wdata1 = 16'($urandom);
         end
         if ($urandom_range(0, 199) == 0) begin
            #1 Resetn = 0; req0 = 0; req1 = 0;
            #2 Resetn = 1;
         end
      end
      req0 = 0; req1 = 0;
      for (int i = 0; i < 4; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
